// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM states, word
// geometry and the layout of a queued fetch entry.
package instr_prefetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_XLEN = 32;
    localparam int WORD_BYTES   = DEFAULT_XLEN / 8;

    // Bytes per instruction word for an arbitrary address/instruction width.
    function automatic int word_bytes(input int xlen);
        return xlen / 8;
    endfunction

    // Queue entry layout: pc in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Prefetch queue: power-of-two ring buffer with wrap-bit pointers, flush,
// and simultaneous push/pop that is honoured even when full.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    // NOTE: storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: single-outstanding fetch FSM feeding a small queue,
// with branch redirect that flushes the queue and drains any stale response.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            isbranchtaken,
    input  logic [XLEN-1:0] branchpc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_current
);

    localparam logic [XLEN-1:0] STEP = XLEN'(word_bytes(XLEN));

    fetch_state_t      state;
    logic [XLEN-1:0]   fpc;
    logic [XLEN-1:0]   req_pc;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;
    logic              req_fire;
    logic              push;
    logic              pop;

    // NOTE: request valid is gated by rst so it drops the instant reset asserts.
    assign mem_req_valid = !rst && (state == FETCH) && !fifo_full;
    assign mem_req_addr  = fpc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Redirect wins over both a push and a dequeue in the same cycle.
    assign push        = (state == WAIT) && mem_rsp_valid && !isbranchtaken;
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready && !isbranchtaken;

    assign {pc_current, instruction} = fifo_empty ? '0 : head;

    instr_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (isbranchtaken),
        .push      (push),
        .push_data ({req_pc, mem_rsp_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            fpc    <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire) begin
                        req_pc <= fpc;
                        state  <= isbranchtaken ? DRAIN : WAIT;
                        fpc    <= isbranchtaken ? branchpc : fpc + STEP;
                    end else if (isbranchtaken) begin
                        fpc <= branchpc;
                    end
                end
                WAIT: begin
                    if (isbranchtaken) begin
                        fpc   <= branchpc;
                        state <= mem_rsp_valid ? FETCH : DRAIN;
                    end else if (mem_rsp_valid) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // Stay here until the stale response has been swallowed.
                    if (isbranchtaken) fpc <= branchpc;
                    if (mem_rsp_valid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: behavioural memory with configurable
// latency, per-scenario tasks with inline expected-value comparisons.
module tb_instr_prefetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        isbranchtaken = 1'b0;
    logic [31:0] branchpc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] pc_current;

    int errors = 0;
    int checks = 0;

    bit          ready_en = 1'b1;
    bit          tag_data = 1'b0;
    int          rsp_delay = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          wait_cnt;
    int          overlap_cnt = 0;
    logic [31:0] acc_q[$];
    logic [31:0] cons_pc_q[$];
    logic [31:0] cons_instr_q[$];

    instr_prefetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isbranchtaken (isbranchtaken),
        .branchpc      (branchpc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .pc_current    (pc_current)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_for(input logic [31:0] addr);
        return tag_data ? (addr ^ TAG) : 32'h0000_0013;
    endfunction

    // Memory model: drives its inputs mid-cycle; an accept seen here lands on the next rising edge.
    always @(negedge clk) begin
        mem_req_ready = ready_en;
        mem_rsp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (wait_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = data_for(pend_addr);
                    pend          = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
            if (mem_req_valid && pend) overlap_cnt++;
            if (mem_req_valid && mem_req_ready) begin
                pend      = 1'b1;
                pend_addr = mem_req_addr;
                wait_cnt  = rsp_delay;
                acc_q.push_back(mem_req_addr);
            end
        end
    end

    task automatic step();
        if (instr_valid && instr_ready && !isbranchtaken) begin
            cons_pc_q.push_back(pc_current);
            cons_instr_q.push_back(instruction);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; isbranchtaken = 1'b0; instr_ready = 1'b1; ready_en = 1'b1; rsp_delay = 0;
        step();
        step();
        acc_q.delete(); cons_pc_q.delete(); cons_instr_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if ({mem_req_valid, instr_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b want 00", {mem_req_valid, instr_valid}); end
        checks++; if ({instruction, pc_current} !== 64'h0) begin errors++; $display("FAIL reset_head: got %h want 0", {instruction, pc_current}); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
        rst = 1'b0;
        #1;
        checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_req: got %b/%h want 1/0", mem_req_valid, mem_req_addr); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL latency_c1: got %b want 0", instr_valid); end
        step();
        checks++; if ({instr_valid, pc_current, instruction} !== {1'b1, 32'h0, 32'h13}) begin errors++; $display("FAIL latency_c2: got %b/%h/%h want 1/0/13", instr_valid, pc_current, instruction); end
    endtask

    task automatic test_stream();
        repeat (14) step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (acc_q.size() <= i || acc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, (acc_q.size() > i) ? acc_q[i] : 32'hx, 32'(4 * i)); end
            checks++; if (cons_pc_q.size() <= i || cons_pc_q[i] !== 32'(4 * i) || cons_instr_q[i] !== 32'h13) begin errors++; $display("FAIL stream_instr[%0d]: got pc %h want %h", i, (cons_pc_q.size() > i) ? cons_pc_q[i] : 32'hx, 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        int chg;
        do_reset();
        instr_ready = 1'b0;
        chg = 0;
        repeat (20) begin
            step();
            if (instr_valid && (pc_current !== 32'h0 || instruction !== 32'h13)) chg++;
        end
        checks++; if (acc_q.size() != DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", acc_q.size(), DEPTH); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", mem_req_valid); end
        checks++; if ({instr_valid, pc_current, instruction} !== {1'b1, 32'h0, 32'h13}) begin errors++; $display("FAIL bp_head: got %b/%h/%h want 1/0/13", instr_valid, pc_current, instruction); end
        checks++; if (chg != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", chg); end
        instr_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (cons_pc_q.size() <= i || cons_pc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_drain[%0d]: got %h want %h", i, (cons_pc_q.size() > i) ? cons_pc_q[i] : 32'hx, 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tag_data = 1'b1; rsp_delay = 2; instr_ready = 1'b0;
        for (int i = 0; i < 40 && acc_q.size() < 3; i++) step();
        checks++; if (acc_q.size() != 3 || acc_q[2] !== 32'h8 || instr_valid !== 1'b1) begin errors++; $display("FAIL rw_setup: got %0d accepts, valid %b want 3/1", acc_q.size(), instr_valid); end
        isbranchtaken = 1'b1; branchpc = 32'h100;
        step();
        isbranchtaken = 1'b0; instr_ready = 1'b1;
        checks++; if ({instr_valid, mem_req_valid} !== 2'b00) begin errors++; $display("FAIL rw_flush: got %b want 00", {instr_valid, mem_req_valid}); end
        repeat (12) step();
        checks++; if (acc_q.size() < 4 || acc_q[3] !== 32'h100) begin errors++; $display("FAIL rw_next_addr: got %h want 100", (acc_q.size() > 3) ? acc_q[3] : 32'hx); end
        checks++; if (cons_pc_q.size() < 1 || cons_pc_q[0] !== 32'h100 || cons_instr_q[0] !== (32'h100 ^ TAG)) begin errors++; $display("FAIL rw_first_pc: got %h want 100", (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        tag_data = 1'b1; rsp_delay = 1;
        for (int i = 0; i < 10 && acc_q.size() < 1; i++) step();
        step();
        isbranchtaken = 1'b1; branchpc = 32'h200;
        step();
        isbranchtaken = 1'b0;
        checks++; if ({mem_req_valid, mem_req_addr, instr_valid} !== {1'b1, 32'h200, 1'b0}) begin errors++; $display("FAIL rr_rereq: got %b/%h/%b want 1/200/0", mem_req_valid, mem_req_addr, instr_valid); end
        repeat (8) step();
        checks++; if (cons_pc_q.size() < 1 || cons_pc_q[0] !== 32'h200) begin errors++; $display("FAIL rr_first_pc: got %h want 200", (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx); end
    endtask

    task automatic test_wrap();
        do_reset();
        tag_data = 1'b1;
        isbranchtaken = 1'b1; branchpc = 32'hFFFF_FFFC;
        step();
        isbranchtaken = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b want 0", mem_req_valid); end
        repeat (10) step();
        checks++; if (acc_q.size() < 3 || acc_q[1] !== 32'hFFFF_FFFC || acc_q[2] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %0d accepts want >=3 with FFFFFFFC then 0", acc_q.size()); end
        checks++; if (cons_pc_q.size() < 2 || cons_pc_q[0] !== 32'hFFFF_FFFC || cons_pc_q[1] !== 32'h0 || cons_instr_q[1] !== TAG) begin errors++; $display("FAIL wrap_pcs: got %h want FFFFFFFC", (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx); end
    endtask

    task automatic test_unaligned_hold();
        do_reset();
        tag_data = 1'b1; ready_en = 1'b0;
        step();
        step();
        checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL hold_req: got %b/%h want 1/0", mem_req_valid, mem_req_addr); end
        isbranchtaken = 1'b1; branchpc = 32'h102;
        step();
        isbranchtaken = 1'b0;
        checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h102}) begin errors++; $display("FAIL unaligned_req: got %b/%h want 1/102", mem_req_valid, mem_req_addr); end
        ready_en = 1'b1;
        repeat (8) step();
        checks++; if (acc_q.size() < 2 || acc_q[0] !== 32'h102 || acc_q[1] !== 32'h106) begin errors++; $display("FAIL unaligned_seq: got %0d accepts want 102,106", acc_q.size()); end
        checks++; if (cons_pc_q.size() < 1 || cons_pc_q[0] !== 32'h102 || cons_instr_q[0] !== (32'h102 ^ TAG)) begin errors++; $display("FAIL unaligned_pc: got %h want 102", (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        tag_data = 1'b0; rsp_delay = 3; instr_ready = 1'b0;
        for (int i = 0; i < 60 && acc_q.size() < 4; i++) step();
        checks++; if (acc_q.size() != 4 || instr_valid !== 1'b1 || pc_current !== 32'h0) begin errors++; $display("FAIL rm_setup: got %0d accepts want 4", acc_q.size()); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_req_valid, instr_valid, instruction, pc_current, mem_req_addr} !== {2'b00, 96'h0}) begin errors++; $display("FAIL rm_async: got %b%b/%h/%h/%h want 00/0/0/0", mem_req_valid, instr_valid, instruction, pc_current, mem_req_addr); end
        step();
        step();
        acc_q.delete(); cons_pc_q.delete(); cons_instr_q.delete();
        rsp_delay = 0; instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rm_restart: got %b/%h want 1/0", mem_req_valid, mem_req_addr); end
        repeat (8) step();
        checks++; if (cons_pc_q.size() < 2 || cons_pc_q[0] !== 32'h0 || cons_pc_q[1] !== 32'h4) begin errors++; $display("FAIL rm_pcs: got %0d instrs want pcs 0,4", cons_pc_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_unaligned_hold();
        test_reset_midwait();
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL single_outstanding: got %0d overlaps want 0", overlap_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter XLEN, default 32, address and instruction width in bits.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 isbranchtaken  input  1  redirect request; sampled each cycle.
REQ-007 branchpc  input  XLEN  redirect target, valid when isbranchtaken=1.
REQ-008 mem_req_valid  output  1  fetch request to instruction memory.
REQ-009 mem_req_ready  input  1  memory accepts request.
REQ-010 mem_req_addr  output  XLEN  byte address of the requested word.
REQ-011 mem_rsp_valid  input  1  read data returned; at most one response per accepted request, in order.
REQ-012 mem_rsp_data  input  XLEN  instruction word; byte 0 is at bits [7:0] (little-endian).
REQ-013 instr_valid  output  1  queue head holds an instruction.
REQ-014 instr_ready  input  1  decode consumes head.
REQ-015 instruction  output  XLEN  head instruction.
REQ-016 pc_current  output  XLEN  address of head instruction.

Function
REQ-017 Transfer on mem_req_valid&&mem_req_ready; instruction dequeued on instr_valid&&instr_ready.
REQ-018 At most one memory request outstanding at any time.
REQ-019 Fetch PC (fpc) increments by XLEN/8 on each accepted request, with modulo-2^XLEN wrap-around.
REQ-020 FSM states: FETCH, WAIT, DRAIN.
REQ-021 FETCH: assert mem_req_valid only when queue free slots exceed 0; on accept go to WAIT.
REQ-022 WAIT: on mem_rsp_valid push {fpc_of_request, mem_rsp_data} into queue, then go to FETCH.
REQ-023 A response push and a dequeue in the same cycle are both honoured when the queue is full at cycle start; occupancy then remains unchanged.
REQ-024 mem_req_valid and mem_req_addr remain stable until accepted, unless a redirect occurs.
REQ-025 Redirect (isbranchtaken=1) in any state: flush queue; set fpc to branchpc in the same cycle; instr_valid is 0 next cycle.
REQ-026 Redirect in FETCH with an unaccepted request: drop the request and re-request at branchpc next cycle.
REQ-027 Redirect in WAIT, or coincident with request accept: go to DRAIN; discard the stale response; then go to FETCH.
REQ-028 Redirect coincident with mem_rsp_valid in WAIT: discard the response and go directly to FETCH.
REQ-029 Redirect in DRAIN: update fpc to the latest branchpc and remain in DRAIN.
REQ-030 Redirect has priority over a simultaneous dequeue or push.
REQ-031 branchpc with low bits not word-aligned is used unchanged; no alignment fault is raised.
REQ-032 Latency: the first instruction is visible one cycle after its mem_rsp_valid cycle, giving a minimum of 2 cycles per instruction with single-outstanding operation.
REQ-033 instruction and pc_current are held stable while instr_valid=1 and instr_ready=0.

Reset
REQ-034 rst asserts asynchronously: state=FETCH, fpc=RESET_PC, queue empty.
REQ-035 During reset: mem_req_valid=0, instr_valid=0, instruction=0, pc_current=0, mem_req_addr=RESET_PC.
REQ-036 Reset during WAIT abandons the outstanding request; the memory must not deliver its response after rst deasserts.
REQ-037 First request issues in the first cycle after rst deasserts.

Structure
REQ-038 Shared package holds the FSM state enumeration, the instruction-word byte width constant (XLEN/8), and the queue entry type {pc, instr}.
REQ-039 The queue is one sub-module, instr_fifo: parameters WIDTH and DEPTH; synchronous push/pop; full/empty flags; flush input; same asynchronous reset.

Verification
REQ-040 Reset, RESET_PC=0, memory returning 0x00000013 at zero wait states -> mem_req_addr sequence 0,4,8,...; instr_valid first asserts 2 cycles after rst deasserts with pc_current=0.
REQ-041 instr_ready=0 for 20 cycles -> exactly DEPTH entries queued, then mem_req_valid=0; head holds pc_current=0 stable.
REQ-042 Redirect to 0x100 while WAIT at address 0x8 -> response for 0x8 discarded, queue empty; next request address 0x100; next delivered pc_current=0x100.
REQ-043 Redirect coincident with mem_rsp_valid -> no push; request to branchpc on the next cycle.
REQ-044 fpc=0xFFFFFFFC with XLEN=32 -> next request address 0x00000000.
REQ-045 rst pulse mid-WAIT with a full queue -> outputs reach reset values immediately; fetch restarts at RESET_PC.
